// File: rtl/cpu_pkg.sv
// cpu_pkg: shared FSM state, fault codes and default fault-return word for the instruction memory.
package cpu_pkg;
  typedef enum logic {ST_LOAD, ST_RUN} state_e;
  typedef enum logic [1:0] {FLT_NONE, FLT_RANGE, FLT_MISALIGN} fault_e;
  localparam logic [31:0] NOP_DEFAULT = 32'hD503201F;
endpackage

// File: rtl/instruction_fetch_mem_if.sv
// instruction_fetch_mem_if: fetch request/response handshake bundle.
interface instruction_fetch_mem_if #(
  parameter int BITSIZE = 32,
  parameter int REGSIZE = 64
);
  logic req_valid;
  logic req_ready;
  logic [REGSIZE-1:0] req_addr;
  logic rsp_valid;
  logic rsp_ready;
  logic [BITSIZE-1:0] rsp_data;
  logic rsp_fault;
  modport master (output req_valid, req_addr, rsp_ready, input req_ready, rsp_valid, rsp_data, rsp_fault);
  modport slave (input req_valid, req_addr, rsp_ready, output req_ready, rsp_valid, rsp_data, rsp_fault);
endinterface

// File: rtl/imem_addr_check.sv
// imem_addr_check: resolves an address to a word index and flags out-of-range or misaligned accesses.
module imem_addr_check
  import cpu_pkg::*;
#(
  parameter int REGSIZE = 64,
  parameter int DEPTH = 64,
  parameter bit BYTE_ADDR = 1'b0
) (
  input  logic [REGSIZE-1:0] addr,
  output logic [$clog2(DEPTH)-1:0] idx,
  output fault_e fault
);
  logic [REGSIZE-1:0] word;
  always_comb begin
    word = BYTE_ADDR ? addr >> 2 : addr;
    idx = word[$clog2(DEPTH)-1:0];
    // full-width compare so high address bits fault instead of wrapping
    fault = (BYTE_ADDR && addr[1:0] != 2'b00) ? FLT_MISALIGN : (word >= REGSIZE'(DEPTH)) ? FLT_RANGE : FLT_NONE;
  end
endmodule

// File: rtl/instruction_fetch_mem.sv
// instruction_fetch_mem: loadable instruction memory with a LOAD/RUN FSM and a registered fetch port.
module instruction_fetch_mem
  import cpu_pkg::*;
#(
  parameter int BITSIZE = 32,
  parameter int REGSIZE = 64,
  parameter int DEPTH = 64,
  parameter bit BYTE_ADDR = 1'b0,
  parameter logic [31:0] NOP_WORD = NOP_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ld_start,
  input  logic ld_en,
  input  logic [REGSIZE-1:0] ld_addr,
  input  logic [BITSIZE-1:0] ld_data,
  input  logic ld_done,
  output logic ld_err,
  output logic running,
  instruction_fetch_mem_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  state_e state_q, state_d;
  logic [BITSIZE-1:0] mem [DEPTH];
  logic [AW-1:0] f_idx, l_idx;
  fault_e f_flt, l_flt;
  logic accept, wr, ld_bad;
  imem_addr_check #(.REGSIZE(REGSIZE), .DEPTH(DEPTH), .BYTE_ADDR(BYTE_ADDR)) u_fetch_chk (
    .addr(bus.req_addr), .idx(f_idx), .fault(f_flt)
  );
  imem_addr_check #(.REGSIZE(REGSIZE), .DEPTH(DEPTH), .BYTE_ADDR(BYTE_ADDR)) u_load_chk (
    .addr(ld_addr), .idx(l_idx), .fault(l_flt)
  );
  always_comb begin
    state_d = ld_start ? ST_LOAD : ld_done ? ST_RUN : state_q;
    running = state_q == ST_RUN;
    bus.req_ready = running && (!bus.rsp_valid || bus.rsp_ready);
    accept = bus.req_valid && bus.req_ready;
    wr = !running && ld_en && l_flt == FLT_NONE;
    ld_bad = !running && ld_en && l_flt != FLT_NONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      ld_err <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data <= '0;
      bus.rsp_fault <= 1'b0;
    end else begin
      state_q <= state_d;
      ld_err <= ld_bad;
      // ld_start flushes any held or just-accepted response
      bus.rsp_valid <= !ld_start && (accept || (bus.rsp_valid && !bus.rsp_ready));
      if (accept) begin
        bus.rsp_data <= (f_flt == FLT_NONE) ? mem[f_idx] : BITSIZE'(NOP_WORD);
        bus.rsp_fault <= f_flt != FLT_NONE;
      end
    end
  end
  always_ff @(posedge clk) if (wr) mem[l_idx] <= ld_data;
endmodule

// File: tb/tb_instruction_fetch_mem.sv
// tb_instruction_fetch_mem: directed stimulus checked per cycle against a queue-based memory model.
module tb_instruction_fetch_mem;
  localparam int BS = 32;
  localparam int RS = 64;
  localparam int DEPTH = 64;
  localparam logic [31:0] NOP = 32'hD503201F;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic ld_start = 0, ld_en = 0, ld_done = 0, ld_err, running;
  logic [RS-1:0] ld_addr = '0;
  logic [BS-1:0] ld_data = '0;
  logic b_ld_en = 0, b_ld_done = 0, b_ld_err, b_running;
  logic [RS-1:0] b_ld_addr = '0;
  logic [BS-1:0] b_ld_data = '0;
  int tests = 0;
  int fails = 0;
  instruction_fetch_mem_if #(.BITSIZE(BS), .REGSIZE(RS)) bus ();
  instruction_fetch_mem_if #(.BITSIZE(BS), .REGSIZE(RS)) bus_b ();
  instruction_fetch_mem #(.BITSIZE(BS), .REGSIZE(RS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_done(ld_done), .ld_err(ld_err), .running(running), .bus(bus.slave)
  );
  instruction_fetch_mem #(.BITSIZE(BS), .REGSIZE(RS), .DEPTH(DEPTH), .BYTE_ADDR(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .ld_start(1'b0), .ld_en(b_ld_en), .ld_addr(b_ld_addr),
    .ld_data(b_ld_data), .ld_done(b_ld_done), .ld_err(b_ld_err), .running(b_running), .bus(bus_b.slave)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model of the word-addressed instance: memory array, run flag and a queue of pending responses.
  typedef struct {logic [31:0] data; logic fault;} rsp_t;
  rsp_t q[$];
  logic [31:0] m_mem [DEPTH];
  bit m_run = 0, m_err = 0, acc;

  function automatic rsp_t model_fetch(input logic [RS-1:0] a);
    rsp_t r;
    r.fault = a >= DEPTH;
    r.data = r.fault ? NOP : m_mem[a[5:0]];
    return r;
  endfunction

  function automatic bit exp_ready();
    return m_run && (q.size() == 0 || bus.rsp_ready);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_run = 0;
      m_err = 0;
    end else begin
      acc = bus.req_valid && exp_ready();
      if (ld_start) q.delete();
      else begin
        if (q.size() > 0 && bus.rsp_ready) void'(q.pop_front());
        if (acc) q.push_back(model_fetch(bus.req_addr));
      end
      m_err = !m_run && ld_en && ld_addr >= DEPTH;
      if (!m_run && ld_en && ld_addr < DEPTH) m_mem[ld_addr[5:0]] = ld_data;
      m_run = ld_start ? 1'b0 : ld_done ? 1'b1 : m_run;
    end
  end

  always @(negedge clk) begin
    chk("running", running, m_run);
    chk("req_ready", bus.req_ready, exp_ready());
    chk("rsp_valid", bus.rsp_valid, q.size() > 0);
    chk("ld_err", ld_err, m_err);
    if (q.size() > 0) begin
      chk("rsp_data", bus.rsp_data, q[0].data);
      chk("rsp_fault", bus.rsp_fault, q[0].fault);
    end
  end

  initial begin
    bus.req_valid = 0; bus.req_addr = '0; bus.rsp_ready = 0;
    bus_b.req_valid = 0; bus_b.req_addr = '0; bus_b.rsp_ready = 1;
    tick(); tick();
    chk("rst_running", running, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_fault", bus.rsp_fault, 0);
    chk("rst_ld_err", ld_err, 0);
    rst_n = 1;
    // fetch attempted while still loading
    bus.req_valid = 1; bus.req_addr = 0;
    tick();
    chk("load_req_ready", bus.req_ready, 0);
    chk("load_no_rsp", bus.rsp_valid, 0);
    bus.req_valid = 0;
    for (int k = 0; k <= 6; k++) begin
      ld_en = 1; ld_addr = k; ld_data = 32'h11111111 * k;
      tick();
    end
    ld_addr = 70; ld_data = 32'h00000BAD;
    tick();
    chk("ld_err_pulse", ld_err, 1);
    ld_en = 0;
    tick();
    chk("ld_err_clear", ld_err, 0);
    ld_done = 1;
    tick();
    ld_done = 0;
    chk("running_after_done", running, 1);
    // back-to-back fetches: in range, word 70 alias, out of range
    bus.rsp_ready = 1; bus.req_valid = 1; bus.req_addr = 3;
    tick();
    chk("fetch3_data", bus.rsp_data, 32'h33333333);
    chk("fetch3_fault", bus.rsp_fault, 0);
    bus.req_addr = 6;
    tick();
    chk("fetch6_data", bus.rsp_data, 32'h66666666);
    bus.req_addr = 64;
    tick();
    chk("fetch64_data", bus.rsp_data, NOP);
    chk("fetch64_fault", bus.rsp_fault, 1);
    bus.req_valid = 0;
    tick();
    chk("drain_valid", bus.rsp_valid, 0);
    // backpressure
    bus.rsp_ready = 0; bus.req_valid = 1; bus.req_addr = 1;
    tick();
    chk("bp_first", bus.rsp_data, 32'h11111111);
    bus.req_addr = 2;
    repeat (3) begin
      tick();
      chk("bp_hold_data", bus.rsp_data, 32'h11111111);
      chk("bp_hold_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1;
    #1;
    chk("bp_release_ready", bus.req_ready, 1);
    tick();
    chk("bp_second", bus.rsp_data, 32'h22222222);
    bus.req_valid = 0;
    tick();
    chk("bp_drained", bus.rsp_valid, 0);
    // ld_start (with ld_done) while a response is held
    bus.rsp_ready = 0; bus.req_valid = 1; bus.req_addr = 0;
    tick();
    bus.req_valid = 0;
    tick();
    chk("held_valid", bus.rsp_valid, 1);
    ld_start = 1; ld_done = 1;
    tick();
    ld_start = 0; ld_done = 0;
    chk("drop_valid", bus.rsp_valid, 0);
    chk("drop_running", running, 0);
    ld_en = 1; ld_addr = 3; ld_data = 32'hDEADBEEF;
    tick();
    ld_en = 0; ld_done = 1;
    tick();
    ld_done = 0; bus.rsp_ready = 1; bus.req_valid = 1; bus.req_addr = 3;
    tick();
    bus.req_valid = 0;
    chk("reload3", bus.rsp_data, 32'hDEADBEEF);
    // loader activity in RUN is ignored
    ld_en = 1; ld_addr = 4; ld_data = 32'h12345678;
    tick();
    ld_addr = 70;
    tick();
    ld_en = 0;
    chk("run_ld_err", ld_err, 0);
    bus.req_valid = 1; bus.req_addr = 4;
    tick();
    bus.req_valid = 0;
    chk("run_ld_ignored", bus.rsp_data, 32'h44444444);
    tick();
    // async reset with a held response
    bus.rsp_ready = 0; bus.req_valid = 1; bus.req_addr = 5;
    tick();
    bus.req_valid = 0;
    chk("pre_rst_valid", bus.rsp_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("async_rsp_valid", bus.rsp_valid, 0);
    chk("async_running", running, 0);
    tick();
    rst_n = 1;
    chk("post_rst_load", running, 0);
    ld_done = 1;
    tick();
    ld_done = 0; bus.rsp_ready = 1; bus.req_valid = 1; bus.req_addr = 3;
    tick();
    chk("kept3", bus.rsp_data, 32'hDEADBEEF);
    bus.req_addr = 5;
    tick();
    chk("kept5", bus.rsp_data, 32'h55555555);
    bus.req_valid = 0;
    tick();
    // byte-addressed instance
    b_ld_en = 1; b_ld_addr = 64'h8; b_ld_data = 32'hCAFEF00D;
    tick();
    b_ld_addr = 64'h5;
    tick();
    chk("b_misalign_ld_err", b_ld_err, 1);
    b_ld_en = 0; b_ld_done = 1;
    tick();
    b_ld_done = 0;
    chk("b_running", b_running, 1);
    bus_b.req_valid = 1; bus_b.req_addr = 64'h6;
    tick();
    chk("b_mis_fault", bus_b.rsp_fault, 1);
    chk("b_mis_data", bus_b.rsp_data, NOP);
    bus_b.req_addr = 64'h8;
    tick();
    chk("b_word2", bus_b.rsp_data, 32'hCAFEF00D);
    chk("b_word2_fault", bus_b.rsp_fault, 0);
    bus_b.req_addr = 64'h100;
    tick();
    chk("b_range_fault", bus_b.rsp_fault, 1);
    bus_b.req_addr = 64'h1_0000_0008;
    tick();
    chk("b_high_bits_fault", bus_b.rsp_fault, 1);
    bus_b.req_valid = 0;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
